instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Switch-driven instruction entry and storage for the 8-bit CPU front end.
//  Four operator entries (opcode, regID1, regID2, immediate) are assembled into one instruction word.
//  Each complete word is committed to a parametrised on-chip instruction store.
//  The fetch stage reads the store back through a registered read port.
//  Internal phase FSM advances on an enter pulse; the external state counter and instructionDone clock are gone.
// PARAMETERS
//  OPCODE_W  4   opcode field width
//  REG_W     3   width of each register-ID field
//  IMM_W     8   immediate field width
//  SW_W      8   switch bus width; must be >= each field width
//  DEPTH     16  instruction store entries (any value >= 2)
//  WRAP      0   0: commit when full is dropped, overflow set; 1: write wraps to entry 0
//  derived: INSTR_W = OPCODE_W+2*REG_W+IMM_W (18); AW = $clog2(DEPTH); CW = $clog2(DEPTH+1)
// PORTS
//  clock         in   1        single clock, all logic on posedge
//  reset_n       in   1        asynchronous, active-low reset
//  switches      in   SW_W     field value for the current phase
//  enter         in   1        synchronous 1-cycle pulse: capture switches into current field
//  cancel        in   1        abandon the partially entered instruction
//  clear         in   1        empty the store: pointer, count and overflow only
//  rd_en         in   1        read request
//  rd_addr       in   AW       read address
//  rd_data       out  INSTR_W  registered read data
//  rd_valid      out  1        rd_data valid, 1 cycle after rd_en
//  phase         out  3        current FSM phase (encoding in package)
//  instruction   out  INSTR_W  {opcode,regID1,regID2,imm} as currently assembled
//  commit        out  1        1-cycle pulse when a word is written to the store
//  instr_count   out  CW       valid entries, saturates at DEPTH
//  full          out  1        instr_count == DEPTH
//  overflow      out  1        sticky; set when a commit is dropped (WRAP=0 only)
// BEHAVIOUR
//  Reset: all outputs and fields 0, phase=P_OP, wr_ptr=0; store contents undefined.
//  FSM P_OP -enter-> P_R1 -enter-> P_R2 -enter-> P_IMM -enter-> P_COMMIT -(1 cycle)-> P_OP.
//  Field capture:
//   - enter in P_OP/R1/R2/IMM loads switches[field_w-1:0] into that field; upper switch bits ignored.
//   - instruction reflects new field on the cycle after enter (registered, no extra delay).
//  Commit (P_COMMIT):
//   - if !full or WRAP=1: write instruction to mem[wr_ptr], commit=1, wr_ptr++.
//   - wr_ptr wraps DEPTH-1 -> 0; instr_count++ saturating at DEPTH.
//   - if full and WRAP=0: no write, commit=0, overflow<=1, pointer/count unchanged.
//   - enter during P_COMMIT is ignored.
//   - fields keep their values after commit; they are overwritten on the next entry.
//  cancel:
//   - any phase except P_COMMIT -> P_OP, all fields cleared to 0, no write.
//   - cancel beats enter in the same cycle; cancel in P_COMMIT is ignored.
//  clear:
//   - wr_ptr=0, instr_count=0, overflow=0; FSM and fields untouched.
//   - clear in the same cycle as a commit: the write to mem[old wr_ptr] still occurs.
//   - pointer/count/overflow end at the clear values (clear wins).
//  Read port:
//   - rd_en at cycle N -> rd_data/rd_valid at N+1; rd_valid=0 when rd_en=0.
//   - rd_data holds its last value when rd_en=0.
//   - rd_addr >= DEPTH returns 0 with rd_valid=1.
//   - read and write to the same address in one cycle returns OLD data (read-before-write).
//  Async reset mid-entry or mid-commit aborts: no write, state as at reset.
// STRUCTURE
//  Package loader_pkg:
//   - phase enum P_OP=0, P_R1=1, P_R2=2, P_IMM=3, P_COMMIT=4.
//   - default field widths; INSTR_W helper function.
//  Sub-module instr_ram (DEPTH x INSTR_W, 1 write / 1 registered read, read-before-write).
//  instr_ram has no reset, so it can map to block RAM.
// TESTING
//  1. Enter switches 1,0,0,0 -> commit pulse; mem[0]=18'h04000, instr_count=1, phase back to P_OP.
//  2. Enter 8'hFA,5,3,8'hC3 -> opcode truncated to 4'hA; mem[0]=18'h2ABC3; rd_en addr0 -> rd_data 18'h2ABC3 next cycle.
//  3. WRAP=0, DEPTH=4: commit 5 words -> full=1 after 4th; 5th dropped, overflow=1, mem[0] unchanged.
//     Then pulse clear -> count=0, overflow=0, full=0.
//  4. WRAP=1, DEPTH=4: commit 5 words -> 5th lands in mem[0], count stays 4, overflow stays 0.
//  5. Enter op,r1 then cancel+enter in the same cycle -> phase=P_OP, instruction=0, no commit, count unchanged.
//  6. Deassert reset_n while in P_IMM -> outputs 0, phase=P_OP immediately.
//     Then read same address as an in-flight commit -> old data returned.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared types, default widths and width helper for the instruction loader
package loader_pkg;

   // Entry phases; P_COMMIT is a single-cycle write slot
   typedef enum logic [2:0] {
      P_OP     = 3'd0,
      P_R1     = 3'd1,
      P_R2     = 3'd2,
      P_IMM    = 3'd3,
      P_COMMIT = 3'd4
   } phase_e;

   localparam int OPCODE_W_DEF = 4;
   localparam int REG_W_DEF    = 3;
   localparam int IMM_W_DEF    = 8;
   localparam int SW_W_DEF     = 8;
   localparam int DEPTH_DEF    = 16;

   // Width of {opcode, regID1, regID2, imm}
   function automatic int instr_width(input int op_w, input int reg_w, input int imm_w);
      return op_w + 2 * reg_w + imm_w;
   endfunction

endpackage

// File: rtl/instruction_loader_ram.sv
// rtl/instruction_loader_ram.sv - instruction store, one write port and one registered read-before-write read port
module instr_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 18,
   parameter int AW    = 4
) (
   input  logic          clock,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   // No reset so the array and output register can map onto block RAM;
   // non-blocking write means a same-address read sees the old word
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - switch-driven instruction assembly, commit into the store and fetch read port
module instruction_loader
   import loader_pkg::*;
#(
   parameter int  OPCODE_W   = OPCODE_W_DEF,
   parameter int  REG_W      = REG_W_DEF,
   parameter int  IMM_W      = IMM_W_DEF,
   parameter int  SW_W       = SW_W_DEF,
   parameter int  DEPTH      = DEPTH_DEF,
   parameter bit  WRAP       = 1'b0,
   localparam int INSTR_W    = instr_width(OPCODE_W, REG_W, IMM_W),
   localparam int AW         = $clog2(DEPTH),
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [SW_W-1:0]    switches,
   input  logic               enter,
   input  logic               cancel,
   input  logic               clear,
   input  logic               rd_en,
   input  logic [AW-1:0]      rd_addr,
   output logic [INSTR_W-1:0] rd_data,
   output logic               rd_valid,
   output logic [2:0]         phase,
   output logic [INSTR_W-1:0] instruction,
   output logic               commit,
   output logic [CW-1:0]      instr_count,
   output logic               full,
   output logic               overflow
);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [AW:0]   DEPTH_A  = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   phase_e              phase_q;
   logic [OPCODE_W-1:0] opcode_q;
   logic [REG_W-1:0]    reg1_q;
   logic [REG_W-1:0]    reg2_q;
   logic [IMM_W-1:0]    imm_q;
   logic                commit_q;

   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;

   logic                rd_valid_q;
   logic                rd_oor_q;
   logic                rd_seen_q;

   logic                full_w;
   logic                do_write;
   logic                in_commit;
   logic                rd_in_range;
   logic [INSTR_W-1:0]  instr_w;
   logic [INSTR_W-1:0]  ram_rdata;

   assign instr_w     = {opcode_q, reg1_q, reg2_q, imm_q};
   assign full_w      = (count_q == DEPTH_C);
   assign in_commit   = (phase_q == P_COMMIT);
   // Writes go straight from the commit phase; a full store only blocks them without wrap
   assign do_write    = in_commit && (!full_w || WRAP);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_A);

   // Phase sequencing, field capture and the commit pulse; cancel outranks enter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q  <= P_OP;
         opcode_q <= '0;
         reg1_q   <= '0;
         reg2_q   <= '0;
         imm_q    <= '0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= do_write;
         if (cancel && !in_commit) begin
            phase_q  <= P_OP;
            opcode_q <= '0;
            reg1_q   <= '0;
            reg2_q   <= '0;
            imm_q    <= '0;
         end else begin
            case (phase_q)
               P_OP: begin
                  if (enter) begin
                     opcode_q <= switches[OPCODE_W-1:0];
                     phase_q  <= P_R1;
                  end
               end
               P_R1: begin
                  if (enter) begin
                     reg1_q  <= switches[REG_W-1:0];
                     phase_q <= P_R2;
                  end
               end
               P_R2: begin
                  if (enter) begin
                     reg2_q  <= switches[REG_W-1:0];
                     phase_q <= P_IMM;
                  end
               end
               P_IMM: begin
                  if (enter) begin
                     imm_q   <= switches[IMM_W-1:0];
                     phase_q <= P_COMMIT;
                  end
               end
               P_COMMIT: phase_q <= P_OP;
               default:  phase_q <= P_OP;
            endcase
         end
      end
   end

   // Store bookkeeping: pointer wrap, saturating count, sticky overflow; clear lands last
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (do_write) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         if (!full_w) begin
            count_d = count_q + 1'b1;
         end
      end else if (in_commit) begin
         overflow_d = 1'b1;
      end
      if (clear) begin
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end
   end

   // Store bookkeeping registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Read-side flags; the RAM output register itself is unreset, so these mask it
   // to zero after reset and for out-of-range addresses, and hold with rd_en low
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_oor_q   <= 1'b0;
         rd_seen_q  <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_oor_q  <= !rd_in_range;
            rd_seen_q <= 1'b1;
         end
      end
   end

   instr_ram #(
      .DEPTH (DEPTH),
      .W     (INSTR_W),
      .AW    (AW)
   ) u_ram (
      .clock   (clock),
      .we_i    (do_write),
      .waddr_i (wr_ptr_q),
      .wdata_i (instr_w),
      .re_i    (rd_en && rd_in_range),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   assign rd_data     = (rd_seen_q && !rd_oor_q) ? ram_rdata : '0;
   assign rd_valid    = rd_valid_q;
   assign phase       = phase_q;
   assign instruction = instr_w;
   assign commit      = commit_q;
   assign instr_count = count_q;
   assign full        = full_w;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  switches;
   logic        enter, cancel, clear, rd_en;
   logic [2:0]  rd_addr;

   logic [17:0] rd_data   [3];
   logic        rd_valid  [3];
   logic [2:0]  phase     [3];
   logic [17:0] instr     [3];
   logic        commit    [3];
   logic [2:0]  count     [3];
   logic        full      [3];
   logic        overflow  [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   // u0: DEPTH=4 drop-on-full, u1: DEPTH=4 wrap, u2: DEPTH=5 (out-of-range reads)
   instruction_loader #(.DEPTH(4), .WRAP(1'b0)) u0 (
      .clock(clock), .reset_n(reset_n), .switches(switches), .enter(enter),
      .cancel(cancel), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr[1:0]),
      .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .phase(phase[0]),
      .instruction(instr[0]), .commit(commit[0]), .instr_count(count[0]),
      .full(full[0]), .overflow(overflow[0]));

   instruction_loader #(.DEPTH(4), .WRAP(1'b1)) u1 (
      .clock(clock), .reset_n(reset_n), .switches(switches), .enter(enter),
      .cancel(cancel), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr[1:0]),
      .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .phase(phase[1]),
      .instruction(instr[1]), .commit(commit[1]), .instr_count(count[1]),
      .full(full[1]), .overflow(overflow[1]));

   instruction_loader #(.DEPTH(5), .WRAP(1'b0)) u2 (
      .clock(clock), .reset_n(reset_n), .switches(switches), .enter(enter),
      .cancel(cancel), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .phase(phase[2]),
      .instruction(instr[2]), .commit(commit[2]), .instr_count(count[2]),
      .full(full[2]), .overflow(overflow[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [7:0] sw);
      switches = sw;
      enter    = 1'b1;
      tick();
      enter    = 1'b0;
   endtask

   task automatic word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      press(a);
      press(b);
      press(c);
      press(d);
      tick();
   endtask

   task automatic rd(input logic [2:0] addr);
      rd_en   = 1'b1;
      rd_addr = addr;
      tick();
      rd_en   = 1'b0;
   endtask

   function automatic logic [17:0] mkw(input logic [3:0] op, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic [7:0] imm);
      return {op, r1, r2, imm};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [17:0] w [5];
      logic [17:0] wa, wb, wc;

      reset_n = 1'b0; switches = '0; enter = 0; cancel = 0; clear = 0; rd_en = 0; rd_addr = '0;
      tick();
      tick();
      chk("reset_phase",    phase[0],    3'd0);
      chk("reset_instr",    instr[0],    18'h0);
      chk("reset_count",    count[0],    3'd0);
      chk("reset_full",     full[0],     1'b0);
      chk("reset_overflow", overflow[0], 1'b0);
      chk("reset_commit",   commit[0],   1'b0);
      chk("reset_rd_valid", rd_valid[0], 1'b0);
      chk("reset_rd_data",  rd_data[0],  18'h0);
      reset_n = 1'b1;
      tick();

      // 1: simple word 1,0,0,0
      press(8'h01);
      chk("t1_phase_r1",  phase[0], 3'd1);
      chk("t1_instr_op",  instr[0], 18'h04000);
      press(8'h00);
      press(8'h00);
      press(8'h00);
      chk("t1_phase_commit", phase[0], 3'd4);
      chk("t1_commit_early", commit[0], 1'b0);
      tick();
      chk("t1_commit",  commit[0], 1'b1);
      chk("t1_count",   count[0],  3'd1);
      chk("t1_phase",   phase[0],  3'd0);
      tick();
      chk("t1_commit_pulse", commit[0], 1'b0);
      rd(3'd0);
      chk("t1_rd_data",  rd_data[0],  18'h04000);
      chk("t1_rd_valid", rd_valid[0], 1'b1);
      tick();
      chk("t1_rd_valid_drop", rd_valid[0], 1'b0);
      chk("t1_rd_data_hold",  rd_data[0],  18'h04000);

      // 2: truncation of wide switch values
      clear = 1'b1; tick(); clear = 1'b0;
      chk("t2_clear_count", count[0], 3'd0);
      word(8'hFA, 8'hFD, 8'h0B, 8'hC3);
      chk("t2_commit", commit[0], 1'b1);
      chk("t2_instr_kept", instr[0], 18'h2ABC3);
      rd(3'd0);
      chk("t2_rd_data", rd_data[0], 18'h2ABC3);

      // 3/4: five commits into DEPTH=4, drop vs wrap
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w[i] = mkw(4'(i + 1), 3'(i), 3'(7 - i), 8'(8'h10 + i));
         word(8'(i + 1), 8'(i), 8'(7 - i), 8'(8'h10 + i));
         chk($sformatf("t3_commit_u0_%0d", i),   commit[0],   (i < 4) ? 1'b1 : 1'b0);
         chk($sformatf("t3_count_u0_%0d", i),    count[0],    (i < 4) ? 3'(i + 1) : 3'd4);
         chk($sformatf("t3_full_u0_%0d", i),     full[0],     (i >= 3) ? 1'b1 : 1'b0);
         chk($sformatf("t3_overflow_u0_%0d", i), overflow[0], (i == 4) ? 1'b1 : 1'b0);
         chk($sformatf("t4_commit_u1_%0d", i),   commit[1],   1'b1);
         chk($sformatf("t4_count_u1_%0d", i),    count[1],    (i < 4) ? 3'(i + 1) : 3'd4);
      end
      chk("t4_overflow_u1", overflow[1], 1'b0);
      chk("t3_count_u2",    count[2],    3'd5);
      chk("t3_full_u2",     full[2],     1'b1);
      rd(3'd0);
      chk("t3_mem0_kept",   rd_data[0], w[0]);
      chk("t4_mem0_wrapped", rd_data[1], w[4]);
      rd(3'd3);
      chk("t3_mem3", rd_data[0], w[3]);
      rd(3'd5);
      chk("oor_rd_data",  rd_data[2],  18'h0);
      chk("oor_rd_valid", rd_valid[2], 1'b1);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("t3_clear_count",    count[0],    3'd0);
      chk("t3_clear_overflow", overflow[0], 1'b0);
      chk("t3_clear_full",     full[0],     1'b0);

      // clear coinciding with a commit: write lands, bookkeeping cleared
      wa = mkw(4'h3, 3'd1, 3'd2, 8'h55);
      wb = mkw(4'h9, 3'd6, 3'd4, 8'hA0);
      word(8'h03, 8'h01, 8'h02, 8'h55);
      press(8'h09); press(8'h06); press(8'h04); press(8'hA0);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr_commit_pulse", commit[0], 1'b1);
      chk("clr_commit_count", count[0],  3'd0);
      rd(3'd1);
      chk("clr_commit_mem1", rd_data[0], wb);

      // 5: cancel beats enter
      press(8'h07);
      press(8'h02);
      cancel = 1'b1; enter = 1'b1; switches = 8'h05;
      tick();
      cancel = 1'b0; enter = 1'b0;
      chk("t5_phase", phase[0], 3'd0);
      chk("t5_instr", instr[0], 18'h0);
      tick();
      chk("t5_commit", commit[0], 1'b0);
      chk("t5_count",  count[0],  3'd0);

      // 6: async reset while in P_IMM
      press(8'h0C); press(8'h01); press(8'h01);
      chk("t6_phase_imm", phase[0], 3'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_phase", phase[0], 3'd0);
      chk("t6_async_instr", instr[0], 18'h0);
      chk("t6_async_count", count[0], 3'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // read-before-write: read mem[0] while it is being overwritten
      wc = mkw(4'h6, 3'd5, 3'd3, 8'h7E);
      press(8'h06); press(8'h05); press(8'h03); press(8'h7E);
      rd_en = 1'b1; rd_addr = 3'd0;
      tick();
      rd_en = 1'b0;
      chk("t6_rbw_commit", commit[0],  1'b1);
      chk("t6_rbw_old",    rd_data[0], wa);
      rd(3'd0);
      chk("t6_rbw_new",    rd_data[0], wc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
